// File: rtl/axi_wr_burst_slave.sv
// ----------------------------------------------------------------------------
// axi_wr_burst_slave - AXI write slave (FIXED/INCR/WRAP) driving a memory strobe port
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_wr_burst_slave #(
  parameter int C_AXI_ID_WIDTH   = 6,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_LEN_WIDTH  = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [C_AXI_ID_WIDTH-1:0]       AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     AWADDR,
  input  logic [C_AXI_LEN_WIDTH-1:0]      AWLEN,
  input  logic [2:0]                      AWSIZE,
  input  logic [1:0]                      AWBURST,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]       BID,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  output logic                            mem_we,
  output logic [C_AXI_ADDR_WIDTH-1:0]     mem_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]     mem_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   mem_wstrb
);

  localparam int C_STRB_W = C_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_DATA = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  localparam logic [1:0] C_FIXED  = 2'b00;
  localparam logic [1:0] C_INCR   = 2'b01;
  localparam logic [1:0] C_WRAP   = 2'b10;
  localparam logic [1:0] C_RSVD   = 2'b11;
  localparam logic [1:0] C_OKAY   = 2'b00;
  localparam logic [1:0] C_SLVERR = 2'b10;

  localparam logic [2:0]                  C_MAX_SIZE = 3'($clog2(C_STRB_W));
  localparam logic [C_AXI_LEN_WIDTH-1:0]  C_LEN_ONE  = 1;
  localparam logic [C_AXI_ADDR_WIDTH-1:0] C_ADDR_ONE = 1;

  logic [1:0]                  state_q, state_d;
  logic                        awready_q, awready_d;
  logic                        wready_q, wready_d;
  logic                        bvalid_q, bvalid_d;
  logic [C_AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [C_AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_AXI_LEN_WIDTH-1:0]  len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic [1:0]                  burst_q, burst_d;
  logic [C_AXI_LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        mem_we_q, mem_we_d;
  logic [C_AXI_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [C_AXI_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [C_STRB_W-1:0]         mem_wstrb_q, mem_wstrb_d;

  logic                        w_aw_err;
  logic                        w_last_beat;
  logic                        w_bad_last;
  logic [C_AXI_ADDR_WIDTH-1:0] w_bytes;
  logic [C_AXI_ADDR_WIDTH-1:0] w_container;
  logic [C_AXI_ADDR_WIDTH-1:0] w_lower;
  logic [C_AXI_ADDR_WIDTH-1:0] w_seq;
  logic [C_AXI_ADDR_WIDTH-1:0] w_addr_next;

  // WRAP needs a power-of-two beat count of at least two
  assign w_aw_err = (AWSIZE > C_MAX_SIZE) || (AWBURST == C_RSVD) ||
                    ((AWBURST == C_WRAP) &&
                     ((AWLEN == '0) || ((AWLEN & (AWLEN + C_LEN_ONE)) != '0)));

  assign w_last_beat = (cnt_q == len_q);
  assign w_bad_last  = (WLAST != w_last_beat);

  assign w_bytes     = C_ADDR_ONE << size_q;
  assign w_container = (C_AXI_ADDR_WIDTH'(len_q) + C_ADDR_ONE) << size_q;
  assign w_lower     = addr_q & ~(w_container - C_ADDR_ONE);
  assign w_seq       = addr_q + w_bytes;

  always_comb begin
    w_addr_next = addr_q;
    case (burst_q)
      C_INCR:  w_addr_next = (addr_q & ~(w_bytes - C_ADDR_ONE)) + w_bytes;
      C_WRAP:  w_addr_next = (w_seq == w_lower + w_container) ? w_lower : w_seq;
      default: w_addr_next = addr_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      C_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID && awready_q) begin
          id_d      = AWID;
          addr_d    = AWADDR;
          len_d     = AWLEN;
          size_d    = AWSIZE;
          burst_d   = AWBURST;
          cnt_d     = '0;
          err_d     = w_aw_err;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = C_DATA;
        end
      end
      C_DATA: begin
        if (WVALID && wready_q) begin
          mem_we_d    = !err_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = WDATA;
          mem_wstrb_d = WSTRB;
          addr_d      = w_addr_next;
          cnt_d       = cnt_q + C_LEN_ONE;
          // Burst closes on the earlier of the beat count or WLAST
          if (w_last_beat || WLAST) begin
            err_d    = err_q || w_bad_last;
            bresp_d  = (err_q || w_bad_last) ? C_SLVERR : C_OKAY;
            bid_d    = id_q;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            state_d  = C_RESP;
          end
        end
      end
      C_RESP: begin
        if (BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = C_IDLE;
        end
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= C_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= C_OKAY;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= C_FIXED;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BID       = bid_q;
  assign BRESP     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_burst_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_wr_burst_slave - scoreboard bench for axi_wr_burst_slave
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axi_wr_burst_slave;

  localparam int IDW = 6;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int SW  = DW / 8;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  logic           ACLK = 1'b0;
  logic           ARESETn;
  logic [IDW-1:0] AWID;
  logic [AW-1:0]  AWADDR;
  logic [LW-1:0]  AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;
  logic [DW-1:0]  WDATA;
  logic [SW-1:0]  WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;
  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [SW-1:0]  mem_wstrb;

  always #5 ACLK = ~ACLK;

  axi_wr_burst_slave #(
    .C_AXI_ID_WIDTH  (IDW),
    .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_DATA_WIDTH(DW),
    .C_AXI_LEN_WIDTH (LW)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWID     (AWID),
    .AWADDR   (AWADDR),
    .AWLEN    (AWLEN),
    .AWSIZE   (AWSIZE),
    .AWBURST  (AWBURST),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WLAST    (WLAST),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BID      (BID),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wr_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } b_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];
  wr_t mon_w;
  b_t  mon_b;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string detail);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, detail);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Address of beat i derived from the burst container, not from the previous beat
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] start, input int len,
                                               input int size, input logic [1:0] burst,
                                               input int i);
    logic [AW-1:0] bytes, cont, lower, ix;
    bytes = 32'd1 << size;
    ix    = 32'(i);
    case (burst)
      FIXED:   return start;
      INCR:    return (i == 0) ? start : (start - (start % bytes)) + ix * bytes;
      default: begin
        cont  = 32'(len + 1) * bytes;
        lower = start - (start % cont);
        return lower + (((start - lower) + ix * bytes) % cont);
      end
    endcase
  endfunction

  // Scoreboard monitor: every DUT write strobe and every B handshake pops one expectation
  always @(negedge ACLK) begin
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        flag("unexpected_mem_we", $sformatf("got write at 0x%0h, expected none", mem_addr));
      end else begin
        mon_w = exp_wr.pop_front();
        cmp("mem_addr", mem_addr, mon_w.addr);
        cmp("mem_wdata", mem_wdata, mon_w.data);
        cmp("mem_wstrb", mem_wstrb, mon_w.strb);
      end
    end
    if (BVALID === 1'b1 && BREADY === 1'b1) begin
      if (exp_b.size() == 0) begin
        flag("unexpected_bresp", $sformatf("got B id=0x%0h resp=%0d, expected none", BID, BRESP));
      end else begin
        mon_b = exp_b.pop_front();
        cmp("bid", BID, mon_b.id);
        cmp("bresp", BRESP, mon_b.resp);
      end
    end
  end

  initial begin
    BREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      BREADY = ($urandom % 3) != 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $fatal(1, "watchdog expired");
  end

  // wlast_pos = beat carrying WLAST (>len means never); rst_beat >= 0 resets on that beat
  task automatic run_txn(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input int size, input logic [1:0] burst, input int wlast_pos,
                         input int gap_mode, input int rst_beat);
    int            nb;
    int            t;
    bit            err;
    bit            bad;
    logic [DW-1:0] d[16];
    logic [SW-1:0] s[16];
    err = (size > 2) || (burst == RSVD) ||
          ((burst == WRAP) && !(len == 1 || len == 3 || len == 7 || len == 15));
    bad = (wlast_pos != len);
    nb  = (wlast_pos < len) ? wlast_pos + 1 : len + 1;
    for (int i = 0; i < nb; i++) begin
      d[i] = $urandom;
      s[i] = SW'($urandom);
      if (!err && (rst_beat < 0 || i < rst_beat))
        exp_wr.push_back('{model_addr(addr, len, size, burst, i), d[i], s[i]});
    end
    if (rst_beat < 0) exp_b.push_back('{id, (err || bad) ? 2'b10 : 2'b00});

    AWID = id; AWADDR = addr; AWLEN = LW'(len); AWSIZE = 3'(size); AWBURST = burst;
    AWVALID = 1'b1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 500) begin step(); t++; end
    if (t >= 500) begin
      flag("aw_timeout", "got AWREADY low for 500 cycles, expected high");
      AWVALID = 1'b0;
      return;
    end
    step();
    AWVALID = 1'b0;
    cmp("awready_after_aw", AWREADY, 0);
    cmp("wready_after_aw", WREADY, 1);

    for (int i = 0; i < nb; i++) begin
      if (gap_mode == 1 && i > 0) step();
      if (gap_mode == 2) repeat ($urandom % 3) step();
      WDATA = d[i]; WSTRB = s[i]; WLAST = (i == wlast_pos); WVALID = 1'b1;
      t = 0;
      while (WREADY !== 1'b1 && t < 500) begin step(); t++; end
      if (t >= 500) begin
        flag("w_timeout", "got WREADY low for 500 cycles, expected high");
        WVALID = 1'b0;
        return;
      end
      if (i == rst_beat) begin
        ARESETn = 1'b0;
        step();
        WVALID = 1'b0; WLAST = 1'b0;
        cmp("rst_awready", AWREADY, 0);
        cmp("rst_wready", WREADY, 0);
        cmp("rst_bvalid", BVALID, 0);
        cmp("rst_mem_we", mem_we, 0);
        cmp("rst_mem_addr", mem_addr, 0);
        cmp("rst_mem_wdata", mem_wdata, 0);
        ARESETn = 1'b1;
        step();
        cmp("rst_awready_release", AWREADY, 1);
        return;
      end
      step();
      WVALID = 1'b0; WLAST = 1'b0;
      cmp("mem_we_latency", mem_we, !err);
    end
    cmp("wready_after_last", WREADY, 0);
    cmp("bvalid_after_last", BVALID, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_b.size() != 0 || exp_wr.size() != 0) && t < 1000) begin step(); t++; end
    if (t >= 1000)
      flag("drain_timeout", $sformatf("got %0d writes / %0d B pending, expected 0",
                                      exp_wr.size(), exp_b.size()));
  endtask

  initial begin
    int            len, size, wl;
    logic [1:0]    burst;
    logic [AW-1:0] addr;
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    repeat (3) step();
    cmp("reset_awready", AWREADY, 0);
    cmp("reset_wready", WREADY, 0);
    cmp("reset_bvalid", BVALID, 0);
    cmp("reset_bid", BID, 0);
    cmp("reset_bresp", BRESP, 0);
    cmp("reset_mem_we", mem_we, 0);
    cmp("reset_mem_addr", mem_addr, 0);
    cmp("reset_mem_wdata", mem_wdata, 0);
    cmp("reset_mem_wstrb", mem_wstrb, 0);
    ARESETn = 1'b1;
    step();
    cmp("awready_after_reset", AWREADY, 1);

    run_txn(6'h05, 32'h0000_0100, 0, 2, INCR,  0, 0, -1);
    run_txn(6'h11, 32'h0000_1000, 3, 2, INCR,  3, 1, -1);
    run_txn(6'h22, 32'h0000_0038, 3, 2, WRAP,  3, 0, -1);
    run_txn(6'h33, 32'h0000_0020, 7, 2, FIXED, 7, 2, -1);
    run_txn(6'h01, 32'h0000_0040, 1, 3, INCR,  1, 0, -1);
    run_txn(6'h02, 32'h0000_0040, 2, 2, WRAP,  2, 0, -1);
    run_txn(6'h03, 32'h0000_0200, 3, 2, INCR,  1, 0, -1);
    run_txn(6'h04, 32'hFFFF_FFFC, 1, 2, INCR,  1, 0, -1);
    run_txn(6'h06, 32'h0000_0300, 2, 2, INCR, 99, 0, -1);
    drain();

    run_txn(6'h2A, 32'h0000_2000, 3, 2, INCR, 3, 0, 2);
    run_txn(6'h2B, 32'h0000_3000, 0, 2, INCR, 0, 0, -1);
    drain();

    for (int n = 0; n < 120; n++) begin
      burst = ($urandom % 10 == 0) ? RSVD : 2'($urandom % 3);
      len   = $urandom % 16;
      size  = ($urandom % 8 == 0) ? 3 : $urandom % 3;
      addr  = $urandom;
      if (burst == WRAP) addr = addr & ~((32'd1 << size) - 32'd1);
      wl    = len;
      if ($urandom % 8 == 0) wl = ($urandom % 2 == 0) ? 99 : $urandom % (len + 1);
      run_txn(6'($urandom), addr, len, size, burst, wl, $urandom % 3, -1);
    end
    drain();
    cmp("leftover_writes", exp_wr.size(), 0);
    cmp("leftover_b", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
